pipe_latch_elastic: RTL and testbench
=====================================

PIPE_LATCH_ELASTIC -- requirements
Module: pipe_latch_elastic

Interface
REQ-001 SHALL have parameter N, default 64: payload width in bits, N >= 1.
REQ-002 SHALL have parameter DEPTH, default 2: number of buffered entries, 1 <= DEPTH <= 16.
REQ-003 SHALL have parameter CW, default 2: count width, equal to ceil(log2(DEPTH+1)).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  discard all buffered entries.
REQ-007 in_valid  input  1  producer offers data_in.
REQ-008 in_ready  output  1  block can accept an entry this cycle.
REQ-009 data_in  input  N  payload from the upstream stage.
REQ-010 out_valid  output  1  data_out holds a valid entry.
REQ-011 out_ready  input  1  downstream stage consumes the head entry this cycle.
REQ-012 data_out  output  N  head-of-queue payload.
REQ-013 count  output  CW  number of occupied entries, 0..DEPTH.
REQ-014 full  output  1  count == DEPTH.
REQ-015 empty  output  1  count == 0.

Function
REQ-016 SHALL act as an in-order FIFO pipeline register: push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-017 in_ready SHALL equal (count < DEPTH) and SHALL be a function of registered state only, with no combinational path from out_ready or in_valid.
REQ-018 out_valid SHALL equal (count != 0) and SHALL be a function of registered state only.
REQ-019 data_out SHALL present the oldest entry when out_valid=1 and SHALL be all-zero when out_valid=0.
REQ-020 Latency: an entry pushed in cycle t SHALL appear on data_out no earlier than cycle t+1; there is no same-cycle bypass.
REQ-021 Push without pop: count +1, write pointer advances. Pop without push: count -1, read pointer advances. Push and pop together: count unchanged, both pointers advance.
REQ-022 Read and write pointers SHALL wrap from DEPTH-1 to 0, including when DEPTH is not a power of two.
REQ-023 When full, in_ready=0, so no push occurs, even if a pop happens in the same cycle; the freed slot is offered in the next cycle.
REQ-024 With DEPTH >= 2 and out_ready held at 1, SHALL sustain one transfer per cycle. With DEPTH=1, throughput SHALL be one transfer per two cycles.
REQ-025 flush=1 SHALL, at the next edge, set count=0 and set both pointers to 0.
REQ-026 flush SHALL take priority: a push in the flush cycle is discarded. A pop in the flush cycle is still a valid transfer to the consumer.
REQ-027 Storage contents are not cleared by rst or flush; only pointers and count are.
REQ-028 in_valid with in_ready=0 SHALL not alter state. The producer holds data_in until accepted.
REQ-029 full and empty SHALL be derived from count and SHALL always be consistent with it.

Reset
REQ-030 While rst=1 at a clock edge, count, read pointer and write pointer SHALL become 0. rst SHALL override flush, push and pop.
REQ-031 Values after reset: out_valid=0, data_out=0, empty=1, full=0, count=0, in_ready=1.
REQ-032 rst asserted mid-stream SHALL drop all buffered entries. No entry SHALL be presented after reset deasserts unless pushed after deassertion.

Verification
REQ-033 Reset, then push 0xA, 0xB, 0xC on consecutive cycles with out_ready=1 (DEPTH=2). Required: out_valid from cycle 2, data_out 0xA, 0xB, 0xC on consecutive cycles, count never exceeds 1.
REQ-034 DEPTH=2, out_ready=0, in_valid=1 for 4 cycles. Required: exactly 2 accepted, full=1 and in_ready=0 after the 2nd push, count=2, data_out=first value.
REQ-035 Full (DEPTH=2), in_valid=1, out_ready=1 for one cycle. Required: one pop, no push, count=1 next cycle, in_ready=1.
REQ-036 count=2 with flush=1, in_valid=1 in the same cycle. Required: count=0, out_valid=0, data_out=0 next cycle; flushed input never appears.
REQ-037 DEPTH=3, stream 10 values 1..10 with random out_ready. Required: output sequence exactly 1..10 in order, pointer wrap exercised.
REQ-038 rst=1 for one cycle while count=2. Required: next cycle count=0, empty=1, in_ready=1; the first value pushed afterward is the first value output.

Source files
------------

// File: rtl/pipe_latch_elastic_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_latch_elastic_if : handshake/payload bundle for pipe_latch_elastic
// Rev 1.0
// ---------------------------------------------------------------------------
interface pipe_latch_elastic_if #(
  parameter int N  = 64,
  parameter int CW = 2
);
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  data_in;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  data_out;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  modport master (
    output flush, in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, count, full, empty
  );

  modport slave (
    input  flush, in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, count, full, empty
  );
endinterface
`default_nettype wire

// File: rtl/pipe_latch_elastic.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_latch_elastic : elastic in-order pipeline buffer of DEPTH entries
// Rev 1.0
// ---------------------------------------------------------------------------
module pipe_latch_elastic #(
  parameter int N     = 64,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  wire logic            clk,
  input  wire logic            rst,
  pipe_latch_elastic_if.slave  bus
);
  localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N-1:0]    r_mem [DEPTH];
  logic [c_PW-1:0] r_rd;
  logic [c_PW-1:0] r_wr;
  logic [CW-1:0]   r_count;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  // Handshake flags depend only on the registered count, never on the peers.
  assign w_in_ready  = (r_count < CW'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid & w_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready;

  function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] p);
    return (p == c_PW'(DEPTH - 1)) ? '0 : p + c_PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= f_next(r_wr);
      if (w_pop)  r_rd <= f_next(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; only pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (w_push && !bus.flush && !rst) r_mem[r_wr] <= bus.data_in;
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.data_out  = w_out_valid ? r_mem[r_rd] : '0;
  assign bus.count     = r_count;
  assign bus.full      = (r_count == CW'(DEPTH));
  assign bus.empty     = (r_count == '0);
endmodule
`default_nettype wire

// File: tb/tb_pipe_latch_elastic.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_latch_elastic : scoreboard bench for DEPTH=2 and DEPTH=3 instances
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pipe_latch_elastic;
  logic clk;
  logic rst;

  pipe_latch_elastic_if #(.N(8), .CW(2)) a ();
  pipe_latch_elastic_if #(.N(8), .CW(2)) b ();

  pipe_latch_elastic #(.N(8), .DEPTH(2), .CW(2)) u_a (.clk(clk), .rst(rst), .bus(a));
  pipe_latch_elastic #(.N(8), .DEPTH(3), .CW(2)) u_b (.clk(clk), .rst(rst), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int        n_assert = 0;
  int        n_fail   = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit        pushed_b;
  int        nb_out = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic post_a();
    chk("a_count", 64'(a.count), 64'(qa.size()));
    chk("a_out_valid", 64'(a.out_valid), 64'(qa.size() != 0));
    chk("a_in_ready", 64'(a.in_ready), 64'(qa.size() < 2));
    chk("a_full", 64'(a.full), 64'(qa.size() == 2));
    chk("a_empty", 64'(a.empty), 64'(qa.size() == 0));
    chk("a_data_out", 64'(a.data_out), (qa.size() != 0) ? 64'(qa[0]) : 64'(0));
  endtask

  task automatic post_b();
    chk("b_count", 64'(b.count), 64'(qb.size()));
    chk("b_out_valid", 64'(b.out_valid), 64'(qb.size() != 0));
    chk("b_in_ready", 64'(b.in_ready), 64'(qb.size() < 3));
    chk("b_full", 64'(b.full), 64'(qb.size() == 3));
    chk("b_empty", 64'(b.empty), 64'(qb.size() == 0));
    chk("b_data_out", 64'(b.data_out), (qb.size() != 0) ? 64'(qb[0]) : 64'(0));
  endtask

  // One clock: pop-compare before the edge, then update models and check state.
  task automatic tick();
    bit pa, ppa, pb, ppb;
    ppa = !rst && a.out_ready && (qa.size() > 0);
    pa  = !rst && a.in_valid  && (qa.size() < 2);
    ppb = !rst && b.out_ready && (qb.size() > 0);
    pb  = !rst && b.in_valid  && (qb.size() < 3);
    if (ppa) begin
      chk("a_pop_data", 64'(a.data_out), 64'(qa[0]));
      void'(qa.pop_front());
    end
    if (ppb) begin
      chk("b_pop_data", 64'(b.data_out), 64'(qb[0]));
      void'(qb.pop_front());
      nb_out++;
    end
    @(posedge clk);
    #1;
    pushed_b = 1'b0;
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a.flush) qa.delete();
      else if (pa) qa.push_back(a.data_in);
      if (b.flush) qb.delete();
      else if (pb) begin
        qb.push_back(b.data_in);
        pushed_b = 1'b1;
      end
    end
    post_a();
    post_b();
  endtask

  initial begin
    rst = 1'b1;
    a.flush = 1'b0; a.in_valid = 1'b0; a.data_in = '0; a.out_ready = 1'b0;
    b.flush = 1'b0; b.in_valid = 1'b0; b.data_in = '0; b.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 64'(a.out_valid), 64'(0));
    chk("rst_data_out", 64'(a.data_out), 64'(0));
    chk("rst_empty", 64'(a.empty), 64'(1));
    chk("rst_in_ready", 64'(a.in_ready), 64'(1));
    rst = 1'b0;
    tick();

    // Streaming through DEPTH=2 with consumer always ready.
    a.out_ready = 1'b1;
    a.in_valid = 1'b1; a.data_in = 8'h0A; tick();
    chk("s_first_visible", 64'(a.data_out), 64'h0A);
    a.data_in = 8'h0B; tick();
    a.data_in = 8'h0C; tick();
    a.in_valid = 1'b0; tick(); tick();

    // Backpressure: four offers, only two accepted.
    a.out_ready = 1'b0; a.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a.data_in = 8'h11 + 8'(i);
      tick();
    end
    chk("bp_full", 64'(a.full), 64'(1));
    chk("bp_count", 64'(a.count), 64'(2));
    chk("bp_head", 64'(a.data_out), 64'h11);

    // Full with pop: no push that cycle.
    a.data_in = 8'h15; a.out_ready = 1'b1; tick();
    chk("fp_count", 64'(a.count), 64'(1));
    chk("fp_in_ready", 64'(a.in_ready), 64'(1));
    a.in_valid = 1'b0; a.out_ready = 1'b0; tick();
    a.out_ready = 1'b1; tick(); tick();
    a.out_ready = 1'b0;

    // Flush while full, with a simultaneous offer.
    a.in_valid = 1'b1; a.data_in = 8'h21; tick();
    a.data_in = 8'h22; tick();
    a.flush = 1'b1; a.data_in = 8'h99; tick();
    a.flush = 1'b0; a.in_valid = 1'b0;
    chk("fl_count", 64'(a.count), 64'(0));
    chk("fl_data_out", 64'(a.data_out), 64'(0));
    tick();

    // Flush with a simultaneous pop: the head still transfers.
    a.in_valid = 1'b1; a.data_in = 8'h31; tick();
    a.data_in = 8'h32; tick();
    a.in_valid = 1'b0; a.flush = 1'b1; a.out_ready = 1'b1; tick();
    a.flush = 1'b0; a.out_ready = 1'b0; tick();

    // Reset mid-stream drops buffered entries.
    a.in_valid = 1'b1; a.data_in = 8'h41; tick();
    a.data_in = 8'h42; tick();
    a.in_valid = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    chk("mr_count", 64'(a.count), 64'(0));
    chk("mr_in_ready", 64'(a.in_ready), 64'(1));
    a.in_valid = 1'b1; a.data_in = 8'h43; tick();
    a.in_valid = 1'b0;
    chk("mr_first_out", 64'(a.data_out), 64'h43);
    a.out_ready = 1'b1; tick(); tick();
    a.out_ready = 1'b0;

    // DEPTH=3 stream with random consumer stalls, wrapping pointers.
    b.in_valid = 1'b1;
    for (int v = 1; v <= 10; v++) begin
      b.data_in = 8'(v);
      pushed_b = 1'b0;
      for (int g = 0; g < 50 && !pushed_b; g++) begin
        b.out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      chk("b_push_accept", 64'(pushed_b), 64'(1));
    end
    b.in_valid = 1'b0; b.out_ready = 1'b1;
    for (int g = 0; g < 20 && qb.size() > 0; g++) tick();
    tick();
    chk("b_drained_empty", 64'(b.empty), 64'(1));
    chk("b_out_total", 64'(nb_out), 64'(10));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
